// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: prescaler, IDLE/RUN/PAUSED FSM, decade carry cascade
// and lap capture register. All outputs registered.
`timescale 1ns/1ps
module bcd_stopwatch_ctrl #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  lap,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [4*DIGITS-1:0]   lap_bcd,
   output logic                  lap_valid,
   output logic                  tick,
   output logic                  running,
   output logic                  overflow,
   output logic [1:0]            state
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [4*DIGITS-1:0] cnt_q, cnt_d, lap_q, lap_d;
   logic                lapv_q, lapv_d;
   logic                tick_q, tick_d;
   logic                run_q, run_d;
   logic                ovf_q, ovf_d;

   logic [4*DIGITS-1:0] cnt_inc;
   logic                carry;
   logic                inc;

   // Ripple the +1 through the digits; a carry out of the top digit means full-scale wrap.
   always_comb begin
      cnt_inc = cnt_q;
      carry   = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (cnt_q[4*k +: 4] == 4'd9) begin
               cnt_inc[4*k +: 4] = 4'd0;
            end else begin
               cnt_inc[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      lap_d   = lap_q;
      lapv_d  = 1'b0;
      tick_d  = 1'b0;
      ovf_d   = ovf_q;
      inc     = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         pre_d   = '0;
         cnt_d   = '0;
         lap_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         if (lap && (state_q != S_IDLE)) begin
            lap_d  = cnt_q;
            lapv_d = 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (!stop && start) state_d = S_RUN;
            end
            S_RUN: begin
               // stop freezes the prescaler and swallows a coincident tick
               if (stop) begin
                  state_d = S_PAUSED;
               end else if (pre_q == PMAX) begin
                  pre_d = '0;
                  inc   = 1'b1;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
            S_PAUSED: begin
               if (!stop && start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
         if (inc) begin
            cnt_d  = cnt_inc;
            tick_d = 1'b1;
            if (carry) ovf_d = 1'b1;
         end
      end
      run_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         lap_q   <= '0;
         lapv_q  <= 1'b0;
         tick_q  <= 1'b0;
         run_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         lap_q   <= lap_d;
         lapv_q  <= lapv_d;
         tick_q  <= tick_d;
         run_q   <= run_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_bcd = cnt_q;
   assign lap_bcd   = lap_q;
   assign lap_valid = lapv_q;
   assign tick      = tick_q;
   assign running   = run_q;
   assign overflow  = ovf_q;
   assign state     = state_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: integer-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_bcd_stopwatch_ctrl;

   localparam int D = 2;
   localparam int P = 3;
   localparam int FULL = 100;

   logic clk;
   logic rst, start, stop, clear, lap;
   logic [4*D-1:0] count_bcd, lap_bcd;
   logic lap_valid, tick, running, overflow;
   logic [1:0] state;

   int n_pass = 0;
   int n_total = 0;

   bcd_stopwatch_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .count_bcd(count_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid), .tick(tick),
      .running(running), .overflow(overflow), .state(state)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [4*D-1:0] to_bcd(input int v);
      logic [4*D-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Model: count as a plain integer, state 0=idle 1=run 2=paused
   int m_st = 0, m_pre = 0, m_cnt = 0, m_lapc = 0;
   bit m_lapv = 0, m_tk = 0, m_ovf = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_pre = 0; m_cnt = 0; m_lapc = 0;
         m_lapv = 0; m_tk = 0; m_ovf = 0;
      end else if (clear) begin
         m_st = 0; m_pre = 0; m_cnt = 0; m_lapc = 0;
         m_lapv = 0; m_tk = 0; m_ovf = 0;
      end else begin
         m_lapv = 0;
         m_tk = 0;
         if (lap && m_st != 0) begin
            m_lapc = m_cnt;
            m_lapv = 1;
         end
         if (m_st == 1) begin
            if (stop) m_st = 2;
            else if (m_pre == P - 1) begin
               m_pre = 0;
               m_tk = 1;
               m_cnt = m_cnt + 1;
               if (m_cnt == FULL) begin
                  m_cnt = 0;
                  m_ovf = 1;
               end
            end else m_pre = m_pre + 1;
         end else if (!stop && start) m_st = 1;
      end
   end

   always @(negedge clk) begin
      if (rst !== 1'bx) begin
         chk("m_count", count_bcd, to_bcd(m_cnt));
         chk("m_lap_bcd", lap_bcd, to_bcd(m_lapc));
         chk("m_lap_valid", lap_valid, m_lapv);
         chk("m_tick", tick, m_tk);
         chk("m_running", running, m_st == 1);
         chk("m_overflow", overflow, m_ovf);
         chk("m_state", state, m_st[1:0]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nt;
      rst = 1'bx; start = 0; stop = 0; clear = 0; lap = 0;
      #1 rst = 1'b1;
      #5 rst = 1'b0;
      @(negedge clk);
      chk("rst_count", count_bcd, 8'h00);
      chk("rst_lap", lap_bcd, 8'h00);
      chk("rst_state", state, 2'b00);
      chk("rst_running", running, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_tick", tick, 1'b0);

      // 30 cycles of RUN: 10 ticks, 0x00 -> 0x10
      start = 1; @(negedge clk); start = 0;
      chk("run_running", running, 1'b1);
      nt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tick) nt++;
      end
      chk("tick_count30", nt, 10);
      chk("count_0x10", count_bcd, 8'h10);
      chk("no_ovf", overflow, 1'b0);

      // 90 more ticks -> full-scale wrap
      repeat (270) @(negedge clk);
      chk("wrap_count", count_bcd, 8'h00);
      chk("wrap_ovf", overflow, 1'b1);
      repeat (3) @(negedge clk);
      chk("post_wrap_count", count_bcd, 8'h01);
      chk("ovf_sticky", overflow, 1'b1);
      clear = 1; @(negedge clk); clear = 0;
      chk("clr_count", count_bcd, 8'h00);
      chk("clr_ovf", overflow, 1'b0);
      chk("clr_state", state, 2'b00);

      // pause at 0x05 with prescaler 1, then resume
      start = 1; @(negedge clk); start = 0;
      repeat (16) @(negedge clk);
      stop = 1; @(negedge clk); stop = 0;
      chk("pause_state", state, 2'b10);
      chk("pause_count", count_bcd, 8'h05);
      nt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tick) nt++;
      end
      chk("pause_ticks", nt, 0);
      chk("pause_hold", count_bcd, 8'h05);
      start = 1; @(negedge clk); start = 0;
      @(negedge clk);
      chk("resume_tick1", tick, 1'b0);
      @(negedge clk);
      chk("resume_tick2", tick, 1'b1);
      chk("resume_count", count_bcd, 8'h06);

      // lap on the 0x07 -> 0x08 tick edge
      repeat (5) @(negedge clk);
      lap = 1; @(negedge clk); lap = 0;
      chk("lap_pre_inc", lap_bcd, 8'h07);
      chk("lap_valid_hi", lap_valid, 1'b1);
      chk("lap_count", count_bcd, 8'h08);
      @(negedge clk);
      chk("lap_valid_lo", lap_valid, 1'b0);

      clear = 1; @(negedge clk); clear = 0;
      lap = 1; @(negedge clk); lap = 0;
      chk("lap_idle_valid", lap_valid, 1'b0);
      chk("lap_idle_bcd", lap_bcd, 8'h00);

      start = 1; @(negedge clk); start = 0;
      repeat (4) @(negedge clk);
      lap = 1; clear = 1; @(negedge clk); lap = 0; clear = 0;
      chk("lapclr_bcd", lap_bcd, 8'h00);
      chk("lapclr_valid", lap_valid, 1'b0);
      chk("lapclr_state", state, 2'b00);

      start = 1; stop = 1; @(negedge clk); start = 0; stop = 0;
      chk("startstop_idle", state, 2'b00);
      chk("startstop_run", running, 1'b0);

      start = 1; @(negedge clk); start = 0;
      repeat (5) @(negedge clk);
      start = 1; clear = 1; @(negedge clk); start = 0; clear = 0;
      chk("startclr_state", state, 2'b00);
      chk("startclr_count", count_bcd, 8'h00);

      // asynchronous reset between edges
      start = 1; @(negedge clk); start = 0;
      repeat (5) @(negedge clk);
      chk("pre_rst_count", count_bcd, 8'h01);
      #2 rst = 1'b1;
      #1;
      chk("async_count", count_bcd, 8'h00);
      chk("async_state", state, 2'b00);
      chk("async_running", running, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      start = 1; @(negedge clk); start = 0;
      repeat (3) @(negedge clk);
      chk("after_rst_count", count_bcd, 8'h01);
      chk("after_rst_tick", tick, 1'b1);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
